// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the MIPS core: owns the PC, strobes IR/regfile/data-memory enables.
// Optional single-step mode (extra step input and PAUSE state) enabled by defining MIPS_SINGLE_STEP_EN.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
`ifdef MIPS_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] address,
  input  logic [31:0] rs_content,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        ir_load,
  output logic        reg_write_en,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  state,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
`ifdef MIPS_SINGLE_STEP_EN
    , PAUSE   = 3'd7
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   retired_q, retired_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
  logic          ir_load_q, ir_load_d;
  logic          reg_write_en_q, reg_write_en_d;
  logic          mem_read_en_q, mem_read_en_d;
  logic          mem_write_en_q, mem_write_en_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          retire;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    retire    = 1'b0;

    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: state_d = (opcode == HALT_OPCODE) ? HALT : EXECUTE;
      EXECUTE: begin
        if (opcode == OP_J) begin
          pc_d   = {6'b0, address};
          retire = 1'b1;
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
          pc_d   = rs_content;
          retire = 1'b1;
        end else if (opcode == OP_BEQ) begin
          pc_d   = alu_zero ? pc_q + 32'd1 + {{16{immediate[15]}}, immediate} : pc_q + 32'd1;
          retire = 1'b1;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = MEMORY;
          cnt_d   = '0;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        // A ready response in the final allowed cycle still completes normally.
        if (mem_ready) begin
          cnt_d = '0;
          if (mem_write_en_q) begin
            pc_d   = pc_q + 32'd1;
            retire = 1'b1;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITEBACK: begin
        pc_d   = pc_q + 32'd1;
        retire = 1'b1;
      end
      HALT: state_d = HALT;
`ifdef MIPS_SINGLE_STEP_EN
      PAUSE: if (step) state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase

    if (retire) begin
      retired_d = retired_q + 32'd1;
`ifdef MIPS_SINGLE_STEP_EN
      state_d   = PAUSE;
`else
      state_d   = FETCH;
`endif
    end

    // Enables are registered from the next state so they line up with the state they belong to.
    ir_load_d      = (state_d == FETCH);
    reg_write_en_d = (state_d == WRITEBACK);
    mem_read_en_d  = (state_d == MEMORY) &&
                     ((state_q == EXECUTE) ? (opcode == OP_LW) : mem_read_en_q);
    mem_write_en_d = (state_d == MEMORY) &&
                     ((state_q == EXECUTE) ? (opcode == OP_SW) : mem_write_en_q);
    busy_d         = (state_d != IDLE) && (state_d != HALT);
    halted_d       = (state_d == HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      retired_q      <= '0;
      cnt_q          <= '0;
      error_q        <= 1'b0;
      ir_load_q      <= 1'b0;
      reg_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      retired_q      <= retired_d;
      cnt_q          <= cnt_d;
      error_q        <= error_d;
      ir_load_q      <= ir_load_d;
      reg_write_en_q <= reg_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
    end
  end

  assign pc           = pc_q;
  assign retired      = retired_q;
  assign state        = state_q;
  assign error        = error_q;
  assign ir_load      = ir_load_q;
  assign reg_write_en = reg_write_en_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against an instruction-level reference model.
module tb_mips_multicycle_ctrl;
  localparam int MEM_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic [5:0]  opcode, funct;
  logic [15:0] immediate;
  logic [25:0] address;
  logic [31:0] rs_content;
  logic        alu_zero, mem_ready;
  logic [31:0] pc, retired;
  logic        ir_load, reg_write_en, mem_read_en, mem_write_en;
  logic [2:0]  state;
  logic        busy, halted, error;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc, exp_ret;
  logic        exp_err;
  int          n_instr = 0;

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.RESET_PC(32'h0), .MEM_TIMEOUT(MEM_TIMEOUT), .HALT_OPCODE(6'h3F)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .opcode(opcode), .funct(funct), .immediate(immediate), .address(address),
    .rs_content(rs_content), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc(pc), .ir_load(ir_load), .reg_write_en(reg_write_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .state(state),
    .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_enables"}, 32'({ir_load, reg_write_en, mem_read_en, mem_write_en}), 32'd0);
    check({tag, "_flags"}, 32'({busy, halted, error}), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; mem_ready = 1'b0; opcode = 6'h0; funct = 6'h0;
    immediate = 16'h0; address = 26'h0; rs_content = 32'h0; alu_zero = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    exp_pc = 32'h0; exp_ret = 32'h0; exp_err = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_fetch", 32'(state), 32'd1);
  endtask

  // Called with the DUT observed in FETCH; holds the instruction fields for its whole life.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                           input logic [25:0] addr, input logic [31:0] rs, input logic z,
                           input int wait_n, input string tag);
    logic [31:0] npc;
    int lat, cycles, m, rd_cnt, wr_cnt, rw_cnt, exp_rd, exp_wr, exp_rw;
    bit halt_exp, err_exp, retire_exp, is_lw, is_sw, done;
    is_lw = (op == 6'h23);
    is_sw = (op == 6'h2B);
    npc = exp_pc; halt_exp = 0; err_exp = 0; retire_exp = 1;
    exp_rd = 0; exp_wr = 0; exp_rw = 0;
    if (op == 6'h3F) begin
      halt_exp = 1; retire_exp = 0; lat = 2;
    end else if (op == 6'h02) begin
      npc = {6'b0, addr}; lat = 3;
    end else if (op == 6'h00 && fn == 6'h08) begin
      npc = rs; lat = 3;
    end else if (op == 6'h04) begin
      npc = z ? exp_pc + 32'd1 + 32'($signed(imm)) : exp_pc + 32'd1; lat = 3;
    end else if (is_lw || is_sw) begin
      if (wait_n < MEM_TIMEOUT) begin
        npc = exp_pc + 32'd1;
        lat = (is_lw ? 5 : 4) + wait_n;
        exp_rd = is_lw ? wait_n + 1 : 0;
        exp_wr = is_sw ? wait_n + 1 : 0;
        exp_rw = is_lw ? 1 : 0;
      end else begin
        err_exp = 1; halt_exp = 1; retire_exp = 0; lat = 3 + MEM_TIMEOUT;
        exp_rd = is_lw ? MEM_TIMEOUT : 0;
        exp_wr = is_sw ? MEM_TIMEOUT : 0;
      end
    end else begin
      npc = exp_pc + 32'd1; lat = 4; exp_rw = 1;
    end

    check({tag, "_irload"}, 32'(ir_load), 32'd1);
    opcode = op; funct = fn; immediate = imm; address = addr; rs_content = rs; alu_zero = z;
    cycles = 0; m = 0; rd_cnt = 0; wr_cnt = 0; rw_cnt = 0; done = 0;
    while (!done) begin
      if (state == 3'd4) begin
        mem_ready = (m == wait_n);
        m++;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clock);
      cycles++;
      check("excl", 32'($countones({ir_load, reg_write_en, mem_read_en, mem_write_en}) <= 1), 32'd1);
      check("busy", 32'(busy), 32'(state != 3'd0 && state != 3'd6));
      rd_cnt += int'(mem_read_en);
      wr_cnt += int'(mem_write_en);
      rw_cnt += int'(reg_write_en);
      if (state == 3'd1 || state == 3'd6 || cycles > 60) done = 1;
    end
    mem_ready = 1'b0;

    if (retire_exp) exp_ret = exp_ret + 32'd1;
    exp_pc = npc;
    exp_err = exp_err | err_exp;
    check({tag, "_lat"}, 32'(cycles), 32'(lat));
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_retired"}, retired, exp_ret);
    check({tag, "_state"}, 32'(state), halt_exp ? 32'd6 : 32'd1);
    check({tag, "_halted"}, 32'(halted), 32'(halt_exp));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_rd"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_wr"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_rw"}, 32'(rw_cnt), 32'(exp_rw));
    n_instr++;
    $display("instr %0d %s op=%02h pc=%08h retired=%0d cycles=%0d", n_instr, tag, op, pc, retired, cycles);
  endtask

  task automatic run_random(input int n);
    logic [5:0] op, fn;
    int cls;
    for (int i = 0; i < n; i++) begin
      cls = $urandom_range(0, 6);
      fn = 6'($urandom);
      case (cls)
        0: op = 6'h02;
        1: begin op = 6'h00; fn = 6'h08; end
        2: op = 6'h04;
        3: op = 6'h23;
        4: op = 6'h2B;
        5: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
        default: begin
          op = 6'($urandom_range(1, 62));
          while (op == 6'h02 || op == 6'h04 || op == 6'h23 || op == 6'h2B)
            op = 6'($urandom_range(1, 62));
        end
      endcase
      run_instr(op, fn, 16'($urandom), 26'($urandom), $urandom, 1'($urandom),
                $urandom_range(0, 6), "rand");
    end
  endtask

  initial begin
    do_reset();
    check_cleared("reset");
    do_start();
    run_instr(6'h00, 6'h20, 16'h0, 26'h0, 32'h0, 1'b0, 0, "rtype");
    run_instr(6'h02, 6'h00, 16'h0, 26'h4, 32'h0, 1'b0, 0, "j4");
    run_instr(6'h04, 6'h00, 16'hFFFE, 26'h0, 32'h0, 1'b1, 0, "beq_taken");
    run_instr(6'h02, 6'h00, 16'h0, 26'h4, 32'h0, 1'b0, 0, "j4b");
    run_instr(6'h04, 6'h00, 16'hFFFE, 26'h0, 32'h0, 1'b0, 0, "beq_not");
    run_instr(6'h02, 6'h00, 16'h0, 26'h3FFFFFF, 32'h0, 1'b0, 0, "j_max");
    run_instr(6'h00, 6'h08, 16'h0, 26'h0, 32'h80, 1'b0, 0, "jr");
    run_instr(6'h00, 6'h08, 16'h0, 26'h0, 32'hFFFFFFFF, 1'b0, 0, "jr_top");
    run_instr(6'h08, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, "wrap");
    run_instr(6'h23, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 3, "lw_stall");
    run_instr(6'h2B, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 14, "sw_last");
    run_instr(6'h23, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 14, "lw_last");
    run_random(60);
    run_instr(6'h2B, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 100, "sw_timeout");
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    check("timeout_stay", 32'(state), 32'd6);
    check("timeout_pc", pc, exp_pc);

    do_reset();
    do_start();
    run_instr(6'h3F, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, "halt");
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    check("halt_stay", 32'(state), 32'd6);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_retired", retired, 32'd0);

    do_reset();
    do_start();
    opcode = 6'h23; mem_ready = 1'b0;
    repeat (5) @(negedge clock);
    check("mid_mem_state", 32'(state), 32'd4);
    check("mid_mem_rd", 32'(mem_read_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_cleared("async_rst");
    @(negedge clock);
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
